// File: rtl/byte_strobe_ram.sv
// Single-port word RAM with per-byte write strobes, valid/ready request and
// response channels, a one-entry registered response and a saturating error counter.
module byte_strobe_ram #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 65536,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ERRCNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ERRCNT_W-1:0]   err_count
);
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned LANE_BITS = $clog2(STRB_W);
    localparam int unsigned WORDS     = MEM_BYTES / STRB_W;
    localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {EMPTY, FULL} rsp_state_e;

    rsp_state_e            state_q;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

    // Word array; kept public by name so the simulator can preload or inspect it.
    logic [DATA_W-1:0]     mem [WORDS];

    logic [31:0]           off;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  accept;
    logic                  wr_en;

    // Addresses below the window wrap to a huge offset and fall out of range.
    always_comb begin
        off         = req_addr - BASE_ADDR;
        in_range    = off < 32'(MEM_BYTES);
        idx         = off[LANE_BITS +: IDX_W];
        req_ready   = (state_q == EMPTY) || rsp_ready;
        accept      = req_valid && req_ready;
        wr_en       = accept && req_write && in_range && resetn;

        rsp_rdata_d = '0;
        if (!req_write && in_range) begin
            rsp_rdata_d = mem[idx];
        end
        rsp_err_d   = !in_range;

        err_count_d = err_count_q;
        if (accept && !in_range && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end
    end

    // NOTE: the array has no reset branch; contents survive resetn, and a reset
    // loop over every word would stop it mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (req_wstrb[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= EMPTY;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (state_q == EMPTY) begin
                if (accept) state_q <= FULL;
            end else if (rsp_ready && !accept) begin
                state_q <= EMPTY;
            end
            if (accept) begin
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= rsp_err_d;
            end
            err_count_q <= err_count_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_byte_strobe_ram.sv
// Self-checking bench for byte_strobe_ram: directed scenarios plus random traffic
// compared against a byte-addressed reference memory and a one-deep response model.
module tb_byte_strobe_ram;
    localparam logic [31:0] M_BASE  = 32'h0000_0000;
    localparam int unsigned M_BYTES = 65536;

    logic clk;
    logic resetn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the default instance and the 2-bit counter instance.
    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] err_count;
    logic        s_req_ready, s_rsp_valid, s_rsp_err;
    logic [31:0] s_rsp_rdata;
    logic [1:0]  s_err_count;

    logic        w_req_valid, w_req_write, w_rsp_ready;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic [7:0]  w_req_wstrb;
    logic        w_req_ready, w_rsp_valid, w_rsp_err;
    logic [63:0] w_rsp_rdata;
    logic [15:0] w_err_count;

    byte_strobe_ram u_dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_count(err_count)
    );

    byte_strobe_ram #(.ERRCNT_W(2)) u_sat (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err), .err_count(s_err_count)
    );

    byte_strobe_ram #(.DATA_W(64), .MEM_BYTES(4096), .BASE_ADDR(32'h8000_0000)) u_w64 (
        .clk(clk), .resetn(resetn), .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_write(w_req_write), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .req_wstrb(w_req_wstrb), .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
        .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err), .err_count(w_err_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference: byte-addressed memory plus the single expected response in flight.
    logic [7:0]  bmem [int unsigned];
    logic        m_valid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    int          m_errs  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
    endtask

    // One clock of the main channel: check req_ready, advance the model, check responses.
    task automatic cycle();
        logic        acc, in_r;
        logic [31:0] off, wbase, rd;
        #1;
        if (!resetn) begin
            m_valid = 1'b0;
            m_errs  = 0;
        end
        check("req_ready", req_ready, !m_valid || rsp_ready);
        acc   = resetn && req_valid && (!m_valid || rsp_ready);
        off   = req_addr - M_BASE;
        in_r  = off < M_BYTES;
        wbase = off & ~32'd3;
        rd    = '0;
        if (acc && in_r) begin
            for (int i = 0; i < 4; i++) begin
                if (req_write && req_wstrb[i]) bmem[wbase + i] = req_wdata[8*i +: 8];
                if (!req_write) rd[8*i +: 8] = bmem.exists(wbase + i) ? bmem[wbase + i] : 8'h00;
            end
        end
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_rdata = rd;
            m_err   = !in_r;
            if (!in_r) m_errs++;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("rsp_valid", rsp_valid, m_valid);
        if (m_valid) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err", rsp_err, m_err);
        end
        check("err_count", err_count, (m_errs > 65535) ? 65535 : m_errs);
        check("err_count_sat", s_err_count, (m_errs > 3) ? 3 : m_errs);
    endtask

    task automatic w_txn(input logic w, input logic [31:0] a, input logic [63:0] d,
                         input logic [7:0] s);
        w_req_valid = 1'b1;
        w_req_write = w;
        w_req_addr  = a;
        w_req_wdata = d;
        w_req_wstrb = s;
        #1;
        check("w64 req_ready", w_req_ready, 1'b1);
        @(posedge clk);
        #1;
        w_req_valid = 1'b0;
        check("w64 rsp_valid", w_rsp_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b1;
        w_req_valid = 1'b0; w_req_write = 1'b0; w_req_addr = '0; w_req_wdata = '0;
        w_req_wstrb = '0; w_rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_err", rsp_err, 1'b0);
        check("reset err_count", err_count, 16'h0);
        resetn = 1'b1;

        // Preload words 0x0, 0x4, 0x8
        set_req(1, 32'h0, 32'h0102_0304, 4'hF); cycle();
        set_req(1, 32'h4, 32'h0506_0708, 4'hF); cycle();
        set_req(1, 32'h8, 32'h090A_0B0C, 4'hF); cycle();

        // Full write then read back
        set_req(1, 32'h10, 32'hDEAD_BEEF, 4'hF); cycle();
        check("t1 wr rdata", rsp_rdata, 32'h0);
        check("t1 wr err", rsp_err, 1'b0);
        set_req(0, 32'h10, 32'h0, 4'h0); cycle();
        check("t1 rd rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("t1 rd err", rsp_err, 1'b0);

        // Partial strobe, misaligned read address
        set_req(1, 32'h20, 32'h1122_3344, 4'hF); cycle();
        set_req(1, 32'h20, 32'hAABB_CCDD, 4'b0101); cycle();
        set_req(0, 32'h23, 32'h0, 4'h0); cycle();
        check("t2 rd rdata", rsp_rdata, 32'h11BB_33DD);
        set_req(1, 32'h24, 32'h0, 4'h0); cycle();
        check("t2 wstrb0 rsp", rsp_valid, 1'b1);

        // Out of range, counter and saturation
        set_req(0, 32'h0001_0000, 32'h0, 4'h0); cycle();
        check("t3 rd err", rsp_err, 1'b1);
        check("t3 rd rdata", rsp_rdata, 32'h0);
        check("t3 err_count 1", err_count, 16'd1);
        set_req(1, 32'h0001_0000, 32'hFFFF_FFFF, 4'hF); cycle();
        check("t3 err_count 2", err_count, 16'd2);
        set_req(0, 32'h0, 32'h0, 4'h0); cycle();
        check("t3 word0 intact", rsp_rdata, 32'h0102_0304);
        set_req(0, 32'hFFFF_FFFC, 32'h0, 4'h0); cycle();
        set_req(1, 32'h0001_0004, 32'h1234_5678, 4'hF); cycle();
        set_req(0, 32'h0002_0000, 32'h0, 4'h0); cycle();
        check("t3 err_count 5", err_count, 16'd5);
        check("t3 sat 5 errors", s_err_count, 2'd3);

        // Back-to-back reads, then a 3-cycle stall
        set_req(0, 32'h0, 32'h0, 4'h0); cycle();
        set_req(0, 32'h4, 32'h0, 4'h0); cycle();
        check("t4 b2b second", rsp_rdata, 32'h0506_0708);
        rsp_ready = 1'b0;
        set_req(0, 32'h8, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t4 stall req_ready", req_ready, 1'b0);
            check("t4 stall rdata", rsp_rdata, 32'h0506_0708);
        end
        rsp_ready = 1'b1;
        cycle();
        check("t4 released", rsp_rdata, 32'h090A_0B0C);
        req_valid = 1'b0; cycle();

        // Reset with a write response pending
        rsp_ready = 1'b0;
        set_req(1, 32'h30, 32'hCAFE_F00D, 4'hF); cycle();
        set_req(1, 32'h30, 32'h0BAD_BEEF, 4'hF);
        resetn = 1'b0;
        #1;
        check("t5 async rsp_valid", rsp_valid, 1'b0);
        check("t5 err_count", err_count, 16'd0);
        cycle();
        req_valid = 1'b0;
        resetn = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        set_req(0, 32'h30, 32'h0, 4'h0); cycle();
        check("t5 write kept", rsp_rdata, 32'hCAFE_F00D);

        // Random traffic over a preloaded window plus out-of-range addresses
        for (int a = 32'h100; a < 32'h200; a += 4) begin
            set_req(1, a, $urandom, 4'hF); cycle();
        end
        for (int n = 0; n < 400; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       req_addr = 32'h0001_0000 + $urandom_range(0, 255);
                1:       req_addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: req_addr = 32'h100 + $urandom_range(0, 255);
            endcase
            req_wdata = $urandom;
            req_wstrb = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cycle();
        cycle();

        // 64-bit instance with a high base address
        w_txn(1, 32'h8000_0FF8, 64'h5A00_0000_0000_0000, 8'h80);
        check("t6 wr err", w_rsp_err, 1'b0);
        check("t6 wr rdata", w_rsp_rdata, 64'h0);
        w_txn(0, 32'h8000_0FF8, 64'h0, 8'h00);
        check("t6 rd top lane", w_rsp_rdata[63:56], 8'h5A);
        check("t6 rd err", w_rsp_err, 1'b0);
        w_txn(0, 32'h7FFF_FFF8, 64'h0, 8'h00);
        check("t6 below base err", w_rsp_err, 1'b1);
        check("t6 below base rdata", w_rsp_rdata, 64'h0);
        w_txn(1, 32'h8000_1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        check("t6 above top err", w_rsp_err, 1'b1);
        check("t6 err_count", w_err_count, 16'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
